// File: rtl/clk_drp_pkg.sv
// clk_drp_pkg: clock wizard DRP register map, LOAD codes, error and state enums.
// Also holds the helpers that map a write index to its address and data.
package clk_drp_pkg;
   localparam logic [11:0] REG_CFG0    = 12'h200;
   localparam logic [11:0] REG_CLKOUT0 = 12'h208;
   localparam logic [11:0] REG_LOAD    = 12'h25C;
   localparam logic [11:0] REG_STATUS  = 12'h004;
   localparam logic [31:0] LOAD_APPLY  = 32'h7;
   localparam logic [31:0] LOAD_SEN    = 32'h2;

   typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_BUS = 2'd1, ERR_TIMEOUT = 2'd2} err_e;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_RESP, S_POLL_AR, S_POLL_R, S_POLL_GAP, S_FINISH
   } state_e;

   function automatic logic [11:0] wr_addr(input logic [1:0] idx);
      return idx == 2'd0 ? REG_CFG0 : idx == 2'd1 ? REG_CLKOUT0 : REG_LOAD;
   endfunction

   function automatic logic [31:0] wr_data(input logic [1:0] idx, input logic [7:0] mult,
                                           input logic [7:0] divclk, input logic [7:0] div0);
      return idx == 2'd0 ? {16'h0, mult, divclk} :
             idx == 2'd1 ? {24'h0, div0} :
             idx == 2'd2 ? LOAD_APPLY : LOAD_SEN;
   endfunction
endpackage

// File: rtl/clk_drp_axil_xfer.sv
// clk_drp_axil_xfer: single-beat AXI-Lite read or write engine.
// done_o is combinational on the final B/R handshake so the sequencer reacts the next cycle.
module clk_drp_axil_xfer #(
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              is_write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              done_o,
   output logic [1:0]        resp_o,
   output logic [31:0]       rdata_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [31:0]       wdata_o,
   output logic [3:0]        wstrb_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic [1:0]        bresp_i,
   input  logic              bvalid_i,
   output logic              bready_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [31:0]       rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o
);
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              aw_q, w_q, b_q, ar_q, r_q;
   logic              wr_fin;

   // AW and W retire independently; B opens once neither is still pending
   assign wr_fin = (aw_q || w_q) && (!aw_q || awready_i) && (!w_q || wready_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         aw_q    <= 1'b0;
         w_q     <= 1'b0;
         b_q     <= 1'b0;
         ar_q    <= 1'b0;
         r_q     <= 1'b0;
      end else begin
         if (start_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            aw_q    <= is_write_i;
            w_q     <= is_write_i;
            ar_q    <= !is_write_i;
         end
         if (aw_q && awready_i) aw_q <= 1'b0;
         if (w_q && wready_i) w_q <= 1'b0;
         if (wr_fin) b_q <= 1'b1;
         if (b_q && bvalid_i) b_q <= 1'b0;
         if (ar_q && arready_i) begin
            ar_q <= 1'b0;
            r_q  <= 1'b1;
         end
         if (r_q && rvalid_i) r_q <= 1'b0;
      end
   end

   assign done_o    = (b_q && bvalid_i) || (r_q && rvalid_i);
   assign resp_o    = b_q ? bresp_i : rresp_i;
   assign rdata_o   = rdata_i;
   assign awaddr_o  = addr_q;
   assign araddr_o  = addr_q;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = 4'hF;
   assign awvalid_o = aw_q;
   assign wvalid_o  = w_q;
   assign bready_o  = b_q;
   assign arvalid_o = ar_q;
   assign rready_o  = r_q;
endmodule

// File: rtl/clk_drp_prog.sv
// clk_drp_prog: reprograms the clock wizard over AXI-Lite (CFG0, CLKOUT0, LOAD x2)
// and then polls the status register for lock with a saturating timeout.
module clk_drp_prog
   import clk_drp_pkg::*;
#(
   parameter int POLL_GAP     = 16,
   parameter int LOCK_TIMEOUT = 100000,
   parameter int ADDR_W       = 11
) (
   input  logic              m_axi_aclk,
   input  logic              m_axi_aresetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [7:0]        req_mult,
   input  logic [7:0]        req_divclk,
   input  logic [7:0]        req_div0,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [31:0]       m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [31:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int GW = $clog2(POLL_GAP + 1);

   state_e            state_q;
   err_e              err_q;
   logic [1:0]        idx_q;
   logic [7:0]        mult_q, divclk_q, div0_q;
   logic [TW-1:0]     tmo_q;
   logic [GW-1:0]     gap_q;
   logic              start_q, ready_q, busy_q, done_q;
   logic              x_done, tmo_hit, polling;
   logic [1:0]        x_resp;
   logic [31:0]       x_rdata;
   logic [ADDR_W-1:0] x_addr;
   logic              unused_rdata;

   assign tmo_hit      = tmo_q == TW'(LOCK_TIMEOUT);
   assign polling      = state_q == S_POLL_AR || state_q == S_POLL_R || state_q == S_POLL_GAP;
   assign x_addr       = ADDR_W'(state_q == S_POLL_AR ? REG_STATUS : wr_addr(idx_q));
   assign unused_rdata = ^x_rdata[31:1];

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q  <= S_IDLE;
         err_q    <= ERR_OK;
         idx_q    <= '0;
         mult_q   <= '0;
         divclk_q <= '0;
         div0_q   <= '0;
         tmo_q    <= '0;
         gap_q    <= '0;
         start_q  <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         if (polling && !tmo_hit) tmo_q <= tmo_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               ready_q <= !(req_valid && ready_q);
               if (req_valid && ready_q) begin
                  mult_q   <= req_mult;
                  divclk_q <= req_divclk;
                  div0_q   <= req_div0;
                  idx_q    <= '0;
                  err_q    <= ERR_OK;
                  busy_q   <= 1'b1;
                  start_q  <= 1'b1;
                  state_q  <= S_WR_ADDR;
               end
            end
            S_WR_ADDR: state_q <= S_WR_RESP;
            S_WR_RESP: if (x_done) begin
               if (x_resp != 2'b00) begin
                  err_q   <= ERR_BUS;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
               end else begin
                  start_q <= 1'b1;
                  idx_q   <= idx_q + 1'b1;
                  tmo_q   <= '0;
                  state_q <= idx_q == 2'd3 ? S_POLL_AR : S_WR_ADDR;
               end
            end
            S_POLL_AR: state_q <= S_POLL_R;
            // a lock seen on the read that coincides with the timeout still wins
            S_POLL_R: if (x_done) begin
               if (x_resp != 2'b00 || x_rdata[0] || tmo_hit) begin
                  err_q   <= x_resp != 2'b00 ? ERR_BUS : x_rdata[0] ? ERR_OK : ERR_TIMEOUT;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
               end else begin
                  gap_q   <= '0;
                  state_q <= S_POLL_GAP;
               end
            end
            S_POLL_GAP: begin
               gap_q <= gap_q + 1'b1;
               if (tmo_hit) begin
                  err_q   <= ERR_TIMEOUT;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
               end else if (gap_q == GW'(POLL_GAP - 1)) begin
                  start_q <= 1'b1;
                  state_q <= S_POLL_AR;
               end
            end
            S_FINISH: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

   clk_drp_axil_xfer #(.ADDR_W(ADDR_W)) u_xfer (
      .clk_i     (m_axi_aclk),
      .rst_ni    (m_axi_aresetn),
      .start_i   (start_q),
      .is_write_i(state_q == S_WR_ADDR),
      .addr_i    (x_addr),
      .wdata_i   (wr_data(idx_q, mult_q, divclk_q, div0_q)),
      .done_o    (x_done),
      .resp_o    (x_resp),
      .rdata_o   (x_rdata),
      .awaddr_o  (m_axi_awaddr),
      .awvalid_o (m_axi_awvalid),
      .awready_i (m_axi_awready),
      .wdata_o   (m_axi_wdata),
      .wstrb_o   (m_axi_wstrb),
      .wvalid_o  (m_axi_wvalid),
      .wready_i  (m_axi_wready),
      .bresp_i   (m_axi_bresp),
      .bvalid_i  (m_axi_bvalid),
      .bready_o  (m_axi_bready),
      .araddr_o  (m_axi_araddr),
      .arvalid_o (m_axi_arvalid),
      .arready_i (m_axi_arready),
      .rdata_i   (m_axi_rdata),
      .rresp_i   (m_axi_rresp),
      .rvalid_i  (m_axi_rvalid),
      .rready_o  (m_axi_rready)
   );
endmodule
